// File: rtl/shift_seq_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// shift_seq_ctrl : load/shift/capture sequencer for one WIDTH-bit shift reg.
// Optional abort port/response flag: define SHIFT_SEQ_CTRL_ABORT_EN. Rev 1.0
// ---------------------------------------------------------------------------
module shift_seq_ctrl #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic             cmd_dir,
  input  logic [CNT_W-1:0] cmd_count,
  output logic             sr_load,
  output logic [WIDTH-1:0] sr_data,
  output logic             sr_shift_en,
  output logic             sr_dir,
  input  logic [WIDTH-1:0] sr_q,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
`ifdef SHIFT_SEQ_CTRL_ABORT_EN
  input  logic             abort,
  output logic             rsp_aborted,
`endif
  output logic             busy
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_LOAD    = 3'd1;
  localparam logic [2:0] S_SHIFT   = 3'd2;
  localparam logic [2:0] S_CAPTURE = 3'd3;
  localparam logic [2:0] S_RESP    = 3'd4;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [2:0]       state_q, state_d;
  logic             ready_q, ready_d;
  logic             load_q, load_d;
  logic             shift_q, shift_d;
  logic             dir_q, dir_d;
  logic [WIDTH-1:0] sdata_q, sdata_d;
  logic             ldir_q, ldir_d;
  logic [CNT_W-1:0] lcnt_q, lcnt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rvalid_q, rvalid_d;
  logic [WIDTH-1:0] rdata_q, rdata_d;
  logic             abt_q, abt_d;
  logic [CNT_W-1:0] w_cnt_sat;

  assign w_cnt_sat = (cmd_count > CNT_MAX) ? CNT_MAX : cmd_count;

  always_comb begin
    state_d  = state_q;
    ready_d  = ready_q;
    load_d   = 1'b0;
    shift_d  = 1'b0;
    dir_d    = dir_q;
    sdata_d  = sdata_q;
    ldir_d   = ldir_q;
    lcnt_d   = lcnt_q;
    cnt_d    = cnt_q;
    rvalid_d = rvalid_q;
    rdata_d  = rdata_q;
    abt_d    = abt_q;

    case (state_q)
      S_IDLE: begin
        ready_d = 1'b1;
        if (cmd_valid && ready_q) begin
          state_d = S_LOAD;
          ready_d = 1'b0;
          load_d  = 1'b1;
          sdata_d = cmd_data;
          ldir_d  = cmd_dir;
          lcnt_d  = w_cnt_sat;
        end
      end
      S_LOAD: begin
        if (lcnt_q == '0) begin
          state_d = S_CAPTURE;
        end else begin
          state_d = S_SHIFT;
          cnt_d   = lcnt_q;
          shift_d = 1'b1;
          dir_d   = ldir_q;
        end
      end
      S_SHIFT: begin
        // The last strobe cycle is the one in which the counter reads 1.
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          state_d = S_CAPTURE;
        end else begin
          shift_d = 1'b1;
        end
      end
      S_CAPTURE: begin
        rdata_d  = sr_q;
        rvalid_d = 1'b1;
        state_d  = S_RESP;
      end
      S_RESP: begin
        if (rsp_ready) begin
          rvalid_d = 1'b0;
          abt_d    = 1'b0;
          ready_d  = 1'b1;
          state_d  = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

`ifdef SHIFT_SEQ_CTRL_ABORT_EN
    if (abort && ((state_q == S_LOAD) || (state_q == S_SHIFT) || (state_q == S_CAPTURE))) begin
      state_d  = S_RESP;
      rdata_d  = sr_q;
      rvalid_d = 1'b1;
      abt_d    = 1'b1;
      load_d   = 1'b0;
      shift_d  = 1'b0;
      cnt_d    = '0;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      ready_q  <= 1'b0;
      load_q   <= 1'b0;
      shift_q  <= 1'b0;
      dir_q    <= 1'b0;
      sdata_q  <= '0;
      ldir_q   <= 1'b0;
      lcnt_q   <= '0;
      cnt_q    <= '0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      abt_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      ready_q  <= ready_d;
      load_q   <= load_d;
      shift_q  <= shift_d;
      dir_q    <= dir_d;
      sdata_q  <= sdata_d;
      ldir_q   <= ldir_d;
      lcnt_q   <= lcnt_d;
      cnt_q    <= cnt_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
      abt_q    <= abt_d;
    end
  end

  assign cmd_ready   = ready_q;
  assign sr_load     = load_q;
  assign sr_data     = sdata_q;
  assign sr_shift_en = shift_q;
  assign sr_dir      = dir_q;
  assign rsp_valid   = rvalid_q;
  assign rsp_data    = rdata_q;
  assign busy        = (state_q != S_IDLE);

`ifdef SHIFT_SEQ_CTRL_ABORT_EN
  assign rsp_aborted = abt_q;
`else
  logic w_unused_abt;
  assign w_unused_abt = abt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_shift_seq_ctrl.sv
`default_nettype none
// tb_shift_seq_ctrl : directed vectors against a zero-fill shift register model.
module tb_shift_seq_ctrl;

  localparam int WIDTH = 4;
  localparam int CNT_W = 3;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [WIDTH-1:0] cmd_data = '0;
  logic             cmd_dir = 1'b0;
  logic [CNT_W-1:0] cmd_count = '0;
  logic             sr_load;
  logic [WIDTH-1:0] sr_data;
  logic             sr_shift_en;
  logic             sr_dir;
  logic [WIDTH-1:0] sr_q = '0;
  logic             rsp_valid;
  logic             rsp_ready = 1'b0;
  logic [WIDTH-1:0] rsp_data;
  logic             busy;
`ifdef SHIFT_SEQ_CTRL_ABORT_EN
  logic             abort = 1'b0;
  logic             rsp_aborted;
`endif

  int n_checks = 0;
  int n_errors = 0;

  shift_seq_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_data    (cmd_data),
    .cmd_dir     (cmd_dir),
    .cmd_count   (cmd_count),
    .sr_load     (sr_load),
    .sr_data     (sr_data),
    .sr_shift_en (sr_shift_en),
    .sr_dir      (sr_dir),
    .sr_q        (sr_q),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_data    (rsp_data),
`ifdef SHIFT_SEQ_CTRL_ABORT_EN
    .abort       (abort),
    .rsp_aborted (rsp_aborted),
`endif
    .busy        (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (sr_load)          sr_q <= sr_data;
    else if (sr_shift_en) sr_q <= sr_dir ? (sr_q >> 1) : (sr_q << 1);
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_ready();
    int guard = 0;
    while (!cmd_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    chk("cmd_ready_wait", {31'd0, cmd_ready}, 32'd1);
  endtask

  // Latency counts the accept edge as 1; sampled after each edge at negedge.
  task automatic run_cmd(input logic [3:0] d, input logic dr, input logic [2:0] c,
                         output logic [3:0] rsp, output int lat, output int loads,
                         output int shifts, output int dirbad, output int overlap);
    loads = 0; shifts = 0; dirbad = 0; overlap = 0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_data = d; cmd_dir = dr; cmd_count = c; rsp_ready = 1'b1;
    wait_ready();
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0; cmd_data = ~d; cmd_dir = ~dr;
    lat = 1;
    while (!rsp_valid && lat < 20) begin
      if (sr_load) loads++;
      if (sr_shift_en) shifts++;
      if (sr_shift_en && (sr_dir !== dr)) dirbad++;
      if (sr_load && sr_shift_en) overlap++;
      @(negedge clk);
      lat++;
    end
    rsp = rsp_data;
    @(negedge clk);
  endtask

  typedef struct {
    logic [3:0] data;
    logic       dir;
    logic [2:0] count;
    logic [3:0] exp_rsp;
    int         exp_shifts;
  } vec_t;

  vec_t vecs [8];

  initial begin
    logic [3:0] rsp;
    int lat, loads, shifts, dirbad, overlap;
    int bp_bad, seen;

    vecs[0] = '{4'b1011, 1'b0, 3'd1, 4'b0110, 1};
    vecs[1] = '{4'b1011, 1'b1, 3'd2, 4'b0010, 2};
    vecs[2] = '{4'b1011, 1'b0, 3'd0, 4'b1011, 0};
    vecs[3] = '{4'b1011, 1'b0, 3'd7, 4'b0000, 4};
    vecs[4] = '{4'b1001, 1'b1, 3'd3, 4'b0001, 3};
    vecs[5] = '{4'b0101, 1'b0, 3'd2, 4'b0100, 2};
    vecs[6] = '{4'b1000, 1'b1, 3'd3, 4'b0001, 3};
    vecs[7] = '{4'b1111, 1'b1, 3'd5, 4'b0000, 4};

    // Reset held: everything low, including cmd_ready.
    @(negedge clk);
    @(negedge clk);
    chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    chk("rst_outputs", {19'd0, sr_load, sr_shift_en, sr_dir, sr_data, rsp_valid, rsp_data, busy}, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("post_rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);

    for (int i = 0; i < 8; i++) begin
      run_cmd(vecs[i].data, vecs[i].dir, vecs[i].count, rsp, lat, loads, shifts, dirbad, overlap);
      chk($sformatf("v%0d_rsp_data", i), {28'd0, rsp}, {28'd0, vecs[i].exp_rsp});
      chk($sformatf("v%0d_latency", i), lat, vecs[i].exp_shifts + 3);
      chk($sformatf("v%0d_load_cycles", i), loads, 1);
      chk($sformatf("v%0d_shift_cycles", i), shifts, vecs[i].exp_shifts);
      chk($sformatf("v%0d_dir_bad", i), dirbad, 0);
      chk($sformatf("v%0d_overlap", i), overlap, 0);
      chk($sformatf("v%0d_idle_after", i), {30'd0, rsp_valid, busy}, 32'd0);
    end

    // Backpressure: response held 5 cycles while a new command waits.
    @(negedge clk);
    rsp_ready = 1'b0;
    cmd_valid = 1'b1; cmd_data = 4'b0110; cmd_dir = 1'b0; cmd_count = 3'd1;
    wait_ready();
    @(posedge clk);
    @(negedge clk);
    cmd_data = 4'b0011; cmd_dir = 1'b1; cmd_count = 3'd1;
    seen = 0;
    while (!rsp_valid && seen < 20) begin
      @(negedge clk);
      seen++;
    end
    chk("bp_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    bp_bad = 0;
    for (int k = 0; k < 5; k++) begin
      if (rsp_data !== 4'b1100 || cmd_ready !== 1'b0 || rsp_valid !== 1'b1) bp_bad++;
      @(negedge clk);
    end
    chk("bp_hold_stable", bp_bad, 0);
    chk("bp_rsp_data", {28'd0, rsp_data}, 32'hC);
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_after_hs_idle", {30'd0, busy, cmd_ready}, 32'd1);
    @(negedge clk);
    chk("bp_new_accepted", {30'd0, busy, cmd_ready}, 32'd2);
    cmd_valid = 1'b0;
    seen = 0;
    while (!rsp_valid && seen < 20) begin
      @(negedge clk);
      seen++;
    end
    chk("bp_second_rsp", {28'd0, rsp_data}, 32'h1);
    @(negedge clk);

    // Reset mid-SHIFT drops the command.
    cmd_valid = 1'b1; cmd_data = 4'b1011; cmd_dir = 1'b1; cmd_count = 3'd3; rsp_ready = 1'b1;
    wait_ready();
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    chk("mid_shift_active", {30'd0, busy, sr_shift_en}, 32'd3);
    rst = 1'b0;
    #1;
    chk("async_rst_outputs", {18'd0, cmd_ready, sr_load, sr_shift_en, sr_dir, sr_data, rsp_valid, rsp_data, busy}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_release_ready", {31'd0, cmd_ready}, 32'd1);
    seen = 0;
    for (int k = 0; k < 10; k++) begin
      if (rsp_valid) seen++;
      @(negedge clk);
    end
    chk("dropped_no_rsp", seen, 0);

`ifdef SHIFT_SEQ_CTRL_ABORT_EN
    // Abort on the second SHIFT cycle returns the pre-shift sample.
    cmd_valid = 1'b1; cmd_data = 4'b1111; cmd_dir = 1'b0; cmd_count = 3'd4; rsp_ready = 1'b1;
    wait_ready();
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    chk("abort_flag", {31'd0, rsp_aborted}, 32'd1);
    chk("abort_rsp_data", {28'd0, rsp_data}, 32'hE);
    @(negedge clk);
    chk("abort_flag_cleared", {30'd0, rsp_aborted, busy}, 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/shift_seq_ctrl.md
Name: shift_seq_ctrl

Overview:
Command sequencer for the team's WIDTH-bit left/right shift register. Accepts a {word, direction, count} command over a valid/ready handshake. Drives the register's load, shift-enable and direction controls for the required number of cycles, then returns the register's final value over a second valid/ready handshake. Sits between a requester (CPU/test FSM) and one shift register instance, so no requester toggles shift controls directly.

Parameters:
WIDTH, 4, data width of the controlled shift register
CNT_W, 3, width of cmd_count; must satisfy 2**CNT_W > WIDTH

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous, active-low reset (asserted at 0)
cmd_valid  in  1  command present
cmd_ready  out  1  controller can accept a command
cmd_data  in  WIDTH  word to load
cmd_dir  in  1  0 = shift left, 1 = shift right
cmd_count  in  CNT_W  number of shift cycles
sr_load  out  1  load strobe to shift register
sr_data  out  WIDTH  load value to shift register
sr_shift_en  out  1  shift-enable strobe to shift register
sr_dir  out  1  shift direction to shift register
sr_q  in  WIDTH  shift register current output
rsp_valid  out  1  result available
rsp_ready  in  1  requester accepts result
rsp_data  out  WIDTH  sampled sr_q after sequence
busy  out  1  high in any state except IDLE

Behaviour:
- Reset (rst=0, async): state=IDLE. cmd_ready=0 while rst low, 1 from first edge after release. sr_load=0, sr_shift_en=0, sr_dir=0, sr_data=0, rsp_valid=0, rsp_data=0, busy=0, internal counter=0.
- States: IDLE, LOAD, SHIFT, CAPTURE, RESP.
- IDLE: cmd_ready=1. On edge with cmd_valid=1: latch data/dir/count, go LOAD. Count > WIDTH saturates to WIDTH.
- LOAD (1 cycle): sr_load=1, sr_data=latched word. If count=0, next CAPTURE; else next SHIFT, counter=count.
- SHIFT: sr_shift_en=1, sr_dir=latched dir. Counter decrements each cycle. Leave after exactly count cycles, to CAPTURE.
- CAPTURE (1 cycle): rsp_data <= sr_q. Register output already reflects the last shift edge. Next RESP.
- RESP: rsp_valid=1; rsp_data held stable until an edge with rsp_ready=1, then IDLE.
- Latency: accept edge to rsp_valid high = count+3 cycles (count=0 gives 3).
- cmd_ready=0 outside IDLE. A command offered during a response is not accepted until the cycle after the response handshake. No back-to-back overlap.
- sr_load and sr_shift_en are never high in the same cycle. Both are registered outputs.
- sr_dir holds its last value outside SHIFT; sr_data holds its last value outside LOAD.
- Reset mid-sequence: immediate return to reset values. Any in-flight command is dropped, no response.
- cmd_dir/cmd_data changes after acceptance have no effect.

Optional Feature:
Macro SHIFT_SEQ_CTRL_ABORT_EN.
- Defined: adds input abort (1 bit). abort=1 on an edge in LOAD/SHIFT/CAPTURE goes to RESP with rsp_data=sr_q sampled that edge. Also adds output rsp_aborted (1 bit), set for that response and cleared on response handshake. abort in IDLE/RESP is ignored.
- Not defined: no abort port, no rsp_aborted port. Sequences always run to completion.

Test Plan:
The bench models the shift register as zero-fill, shifting on sr_shift_en.
- Reset: rst=0 mid-SHIFT with count=3 -> all outputs 0 asynchronously, busy=0; after release, cmd_ready=1 and no rsp_valid ever issued for the dropped command.
- Left shift: data=4'b1011, dir=0, count=1 -> one sr_load cycle, one sr_shift_en cycle, rsp_data=4'b0110, rsp_valid 4 cycles after accept.
- Right shift: data=4'b1011, dir=1, count=2 -> two sr_shift_en cycles with sr_dir=1, rsp_data=4'b0010.
- Boundaries: count=0 gives rsp_data=4'b1011 after 3 cycles. count=7 saturates to 4 shift cycles, rsp_data=4'b0000.
- Backpressure: hold rsp_ready=0 for 5 cycles with cmd_valid=1 -> rsp_data stable, cmd_ready=0 throughout; the new command is accepted only after the response handshake.
- ABORT_EN build: abort=1 on second SHIFT cycle of data=4'b1111, dir=0, count=4 -> rsp_aborted=1, rsp_data=4'b1110.
